// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch stage with a decoupling prefetch queue. It issues
// sequential program-memory reads, absorbs the memory's one-cycle read
// latency, and buffers up to DEPTH fetched {addr, ins} pairs for decode.
// A jump redirect empties the queue, squashes any in-flight response and
// restarts fetching at the jump target.
//
// Parameters
//   ADDR_W    program address width
//   INS_W     instruction width
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   mem_addr     program memory read address
//   mem_rd_en    read request; data returns on mem_rdata one cycle later
//   mem_rdata    read data for the previous cycle's request
//   jmp_loc      redirect target
//   pc_mux_sel   redirect strobe (one cycle per jump)
//   ins          head instruction (0 when ins_valid = 0)
//   ins_addr     address of ins (0 when ins_valid = 0)
//   ins_valid    head entry valid
//   ins_ready    decode accepts; pop = ins_valid & ins_ready
//   occupancy    entries currently held in the queue
//
// Build option
//   FETCH_QUEUE_BYPASS_EN  when defined, a response arriving into an empty
//                          queue is presented to decode in the same cycle
//                          and, if accepted, never enters the queue.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INS_W    = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd_en,
    input  logic [INS_W-1:0]             mem_rdata,
    input  logic [ADDR_W-1:0]            jmp_loc,
    input  logic                         pc_mux_sel,
    output logic [INS_W-1:0]             ins,
    output logic [ADDR_W-1:0]            ins_addr,
    output logic                         ins_valid,
    input  logic                         ins_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Architectural state
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [INS_W-1:0]  fifo_ins_q  [DEPTH];

    // Per-cycle control
    logic          redirect;
    logic          q_nonempty;
    logic          bypass;
    logic          head_valid;
    logic          pop;
    logic          fifo_pop;
    logic          push;
    logic          issue;
    logic [CW:0]   used_after_pop;

    always_comb begin
        // A redirect is ignored while reset is held so that the outputs
        // show their reset values for the whole reset interval.
        redirect   = pc_mux_sel & ~reset;
        q_nonempty = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = ~q_nonempty & pend_q & ~redirect;
`else
        bypass = 1'b0;
`endif

        // Decode never sees a head entry in a redirect cycle: whatever is
        // queued belongs to the old instruction stream.
        head_valid = ~redirect & (q_nonempty | bypass);

        ins       = '0;
        ins_addr  = '0;
        if (head_valid) begin
            if (q_nonempty) begin
                ins      = fifo_ins_q[rd_ptr_q];
                ins_addr = fifo_addr_q[rd_ptr_q];
            end else begin
                ins      = mem_rdata;
                ins_addr = pend_addr_q;
            end
        end
        ins_valid = head_valid;

        pop      = head_valid & ins_ready;
        fifo_pop = pop & q_nonempty;

        // The returning response is stored unless it is squashed by a
        // redirect or consumed directly through the bypass path.
        push = pend_q & ~redirect & ~(bypass & ins_ready);

        // The in-flight request already owns a slot, so holding ins_ready
        // low can never overflow the queue.
        used_after_pop = {1'b0, count_q} + (CW+1)'(pend_q) - (CW+1)'(pop);
        issue          = redirect | (used_after_pop < (CW+1)'(DEPTH));

        mem_rd_en = issue & ~reset;
        mem_addr  = redirect ? jmp_loc : fetch_pc_q;

        occupancy = count_q;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pend_d      = mem_rd_en;
        pend_addr_d = mem_addr;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (redirect) begin
            fetch_pc_d = jmp_loc + ADDR_W'(1);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (mem_rd_en) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            rd_ptr_d = rd_ptr_q + PW'(fifo_pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_ins_q[i]  <= '0;
            end
        end else if (push) begin
            fifo_addr_q[wr_ptr_q] <= pend_addr_q;
            fifo_ins_q[wr_ptr_q]  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          AW  = 16;
    localparam int          IW  = 32;
    localparam int          D   = 4;
    localparam logic [15:0] RPC = 16'h0010;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: default geometry, RESET_PC = 0x0010
    logic          reset;
    logic [15:0]   mem_addr;
    logic          mem_rd_en;
    logic [31:0]   mem_rdata = '0;
    logic [15:0]   jmp_loc;
    logic          pc_mux_sel;
    logic [31:0]   ins;
    logic [15:0]   ins_addr;
    logic          ins_valid;
    logic          ins_ready;
    logic [2:0]    occupancy;

    // Wrap DUT: 8-bit addresses, DEPTH=2, RESET_PC = 0xFE
    logic          rst_w;
    logic [7:0]    w_mem_addr;
    logic          w_rd_en;
    logic [31:0]   w_rdata = '0;
    logic [31:0]   w_ins;
    logic [7:0]    w_addr;
    logic          w_valid;
    logic [1:0]    w_occ;

    fetch_queue #(.ADDR_W(AW), .INS_W(IW), .DEPTH(D), .RESET_PC(RPC)) u_dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
        .ins(ins), .ins_addr(ins_addr), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .occupancy(occupancy)
    );

    fetch_queue #(.ADDR_W(8), .INS_W(32), .DEPTH(2), .RESET_PC(8'hFE)) u_wrap (
        .clk(clk), .reset(rst_w),
        .mem_addr(w_mem_addr), .mem_rd_en(w_rd_en), .mem_rdata(w_rdata),
        .jmp_loc(8'h00), .pc_mux_sel(1'b0),
        .ins(w_ins), .ins_addr(w_addr), .ins_valid(w_valid),
        .ins_ready(1'b1), .occupancy(w_occ)
    );

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    function automatic logic [31:0] memf8(input logic [7:0] a);
        return {a ^ 8'h5A, 16'h1234, a};
    endfunction

    // Synchronous-read program memories
    always @(posedge clk) if (mem_rd_en) mem_rdata <= memf(mem_addr);
    always @(posedge clk) if (w_rd_en)   w_rdata   <= memf8(w_mem_addr);

    // Accepted stream of the wrap DUT
    logic [7:0]  w_seen     [4];
    logic [31:0] w_seen_ins [4];
    int          w_n = 0;
    always @(negedge clk) begin
        if (!rst_w && w_valid && w_n < 4) begin
            w_seen[w_n]     <= w_addr;
            w_seen_ins[w_n] <= w_ins;
            w_n             <= w_n + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the queue as a list of held addresses, plus the
    // outstanding request and the address the stream should continue at.
    logic [15:0] mq [$];
    bit          m_pend;
    logic [15:0] m_pend_addr;
    logic [15:0] m_pc;
    logic [15:0] exp_next;
    int          step_no;
    int          first_valid;

    task automatic model_reset();
        mq.delete();
        m_pend      = 1'b0;
        m_pend_addr = '0;
        m_pc        = RPC;
        exp_next    = RPC;
        step_no     = 0;
        first_valid = -1;
    endtask

    task automatic step(input bit redir, input logic [15:0] jmp, input bit rdy);
        bit          bp;
        bit          v;
        bit          pop;
        bit          rd;
        int          used;
        logic [15:0] head;
        @(negedge clk);
        pc_mux_sel = redir;
        jmp_loc    = jmp;
        ins_ready  = rdy;
        #1;
        bp   = 1'b0;
        pop  = 1'b0;
        head = '0;
        if (redir) begin
            v  = 1'b0;
            rd = 1'b1;
            check_val("redir_addr", mem_addr, jmp);
        end else begin
            bp   = BYP && (mq.size() == 0) && m_pend;
            v    = (mq.size() > 0) || bp;
            head = (mq.size() > 0) ? mq[0] : m_pend_addr;
            pop  = v && rdy;
            used = mq.size() + int'(m_pend) - int'(pop);
            rd   = (used < D);
            if (rd) check_val("issue_addr", mem_addr, m_pc);
        end
        check_val("ins_valid", ins_valid, v);
        check_val("mem_rd_en", mem_rd_en, rd);
        check_val("occupancy", occupancy, mq.size());
        if (v) begin
            check_val("ins_addr", ins_addr, head);
            check_val("ins", ins, memf(head));
        end else begin
            check_val("ins_addr_zero", ins_addr, 16'h0);
            check_val("ins_zero", ins, 32'h0);
        end
        if (v && rdy) begin
            check_val("seq_addr", ins_addr, exp_next);
            exp_next = exp_next + 16'h1;
        end
        if (v && first_valid < 0) first_valid = step_no;
        step_no++;

        if (redir) begin
            mq.delete();
            m_pend      = 1'b1;
            m_pend_addr = jmp;
            m_pc        = jmp + 16'h1;
            exp_next    = jmp;
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (m_pend && !(bp && pop)) mq.push_back(m_pend_addr);
            m_pend      = rd;
            m_pend_addr = m_pc;
            if (rd) m_pc = m_pc + 16'h1;
        end
    endtask

    logic [7:0] exp_w [4];

    initial begin
        reset      = 1'b1;
        rst_w      = 1'b1;
        pc_mux_sel = 1'b0;
        jmp_loc    = '0;
        ins_ready  = 1'b0;
        exp_w[0] = 8'hFE; exp_w[1] = 8'hFF; exp_w[2] = 8'h00; exp_w[3] = 8'h01;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_val("rst_valid", ins_valid, 1'b0);
        check_val("rst_occ", occupancy, 3'd0);
        check_val("rst_rden", mem_rd_en, 1'b0);
        check_val("rst_addr", mem_addr, RPC);
        check_val("rst_ins", ins, 32'h0);
        check_val("rst_ins_addr", ins_addr, 16'h0);

        @(posedge clk); #2;
        reset = 1'b0;
        rst_w = 1'b0;
        model_reset();

        // Straight-line fetch
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b1);
        check_val("latency", first_valid, BYP ? 1 : 2);

        // Backpressure from an empty queue
        step(1'b1, 16'h0100, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0);
        check_val("bp_occ", occupancy, 3'd4);
        check_val("bp_rden", mem_rd_en, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);

        // Redirect with three queued entries and one in flight
        step(1'b1, 16'h0300, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0);
        check_val("pre_redir_occ", occupancy, 3'd3);
        step(1'b1, 16'h0200, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1);

        // Main address space wrap
        step(1'b1, 16'hFFFE, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);

        // Randomized traffic with back-to-back redirects possible
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Fill, then reset asynchronously mid-cycle
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b0);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_valid", ins_valid, 1'b0);
        check_val("mid_rst_occ", occupancy, 3'd0);
        check_val("mid_rst_rden", mem_rd_en, 1'b0);
        check_val("mid_rst_addr", mem_addr, RPC);
        @(posedge clk); #2;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);
        check_val("post_rst_lat", first_valid, BYP ? 1 : 2);

        // Wrap DUT stream
        check_val("wrap_count", w_n, 4);
        for (int i = 0; i < 4; i++) begin
            check_val("wrap_addr", w_seen[i], exp_w[i]);
            check_val("wrap_ins", w_seen_ins[i], memf8(exp_w[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue. It generates sequential program-memory addresses, absorbs the memory's one-cycle read latency, and buffers up to DEPTH fetched instructions. It presents them to decode over a valid/ready handshake and flushes cleanly on jumps. It sits between the synchronous-read program memory and the decode stage, replacing the single-register hold/stall path of the previous fetch logic.

## Interface
- ADDR_W, 16, program address width
- INS_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- mem_addr  out  ADDR_W  program memory read address
- mem_rd_en  out  1  read request; data returns on mem_rdata exactly one cycle later
- mem_rdata  in  INS_W  read data for the request issued in the previous cycle
- jmp_loc  in  ADDR_W  redirect target
- pc_mux_sel  in  1  redirect strobe, one cycle per jump
- ins  out  INS_W  head instruction; 0 when ins_valid=0
- ins_addr  out  ADDR_W  address of ins; 0 when ins_valid=0
- ins_valid  out  1  head entry is valid
- ins_ready  in  1  decode accepts; pop = ins_valid & ins_ready
- occupancy  out  $clog2(DEPTH+1)  entries currently held

## Operation
- State: fetch_pc, pending flag plus pending address (request in flight), circular FIFO of {addr, ins}, rd/wr pointers (log2 DEPTH bits, natural wrap), count.
- Issue rule: mem_rd_en=1 when count + pending − pop < DEPTH. Slot accounting is taken after this cycle's pop.
- Normal issue: mem_addr=fetch_pc; fetch_pc ← fetch_pc+1 mod 2^ADDR_W. 2^ADDR_W−1 wraps to 0.
- Response: in the cycle after an issue, {pending address, mem_rdata} is pushed unless it is squashed.
- Redirect (pc_mux_sel=1):
  - The queue is emptied and any in-flight response is squashed.
  - mem_addr=jmp_loc, mem_rd_en=1 unconditionally that cycle, and fetch_pc ← jmp_loc+1.
  - ins_valid is forced 0 that cycle, so no pop occurs.
- Back-to-back redirects: the last one wins, and every earlier in-flight response is squashed.
- Full: no issue. ins_ready held low never overflows because pending is counted.
- Empty: ins_valid=0, and outputs are zeroed.
- Simultaneous push and pop: count is unchanged and both pointers advance.

## Timing
- Reset values:
  - ins=0, ins_addr=0, ins_valid=0, occupancy=0, mem_rd_en=0, mem_addr=RESET_PC
  - fetch_pc=RESET_PC, pending=0
- First cycle after reset deasserts: mem_rd_en=1, mem_addr=RESET_PC.
- Issue-to-ins_valid latency without bypass: 2 cycles. Issue at N, push at end of N+1, valid at N+2.
- Redirect-to-target-valid latency: 2 cycles (1 with bypass).
- Sustained throughput is 1 instruction per cycle with ins_ready held high, for any DEPTH ≥2.
- Reset asserted mid-operation:
  - Immediately: queue emptied, pending dropped, outputs return to reset values.
  - A response arriving after reset releases is ignored.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count=0 and an unsquashed response arrives, ins/ins_addr/ins_valid are driven combinationally from mem_rdata/pending address in that same cycle.
  - If ins_ready=1, the entry is consumed and not pushed.
  - Latency drops to 1 cycle.
- Undefined: every response goes through the queue. Outputs are purely registered-path, with latency 2.

## Test plan
- Straight-line fetch: RESET_PC=0x0010, ins_ready=1, memory returns its address. ins_addr sequence is 0x0010, 0x0011, 0x0012… one per cycle after the initial latency; mem_rd_en never stalls.
- Backpressure: ins_ready=0 for 10 cycles from an empty queue, DEPTH=4. occupancy saturates at 4, mem_rd_en=0 once count+pending=4, and no entry is lost or duplicated on release.
- Redirect with work in flight: queue holds 3 entries plus 1 pending; pulse pc_mux_sel with jmp_loc=0x0200. ins_valid=0 that cycle, the stale response is dropped, and the next accepted ins_addr is 0x0200 then 0x0201.
- Wrap-around: ADDR_W=8, RESET_PC=0xFE. ins_addr sequence is 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-operation: assert reset asynchronously with a full queue. ins_valid and occupancy go to 0 before the next edge, and refetch resumes at RESET_PC.
- Bypass build: issue into an empty queue. ins_valid rises 1 cycle after mem_rd_en with FETCH_QUEUE_BYPASS_EN defined, and 2 cycles after without it.
